alu_multicycle: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_divider.sv | 72 +++++++
 rtl/alu_multicycle.sv | 200 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multicycle ALU.
//   - Opcode constants ALU_ADD .. ALU_REM (4-bit alu_func encodings)
//   - FSM state type alu_state_t (IDLE, DIV)
//   - Bit positions of the flags inside the packed flag register
// No ports; imported by alu_multicycle and alu_divider.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SHL = 4'b0101;
   localparam logic [3:0] ALU_SHR = 4'b0110;
   localparam logic [3:0] ALU_NOT = 4'b0111;
   localparam logic [3:0] ALU_DIV = 4'b1000;
   localparam logic [3:0] ALU_REM = 4'b1001;

   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } alu_state_t;

   localparam int FLAG_C    = 0;
   localparam int FLAG_Z    = 1;
   localparam int FLAG_V    = 2;
   localparam int FLAG_S    = 3;
   localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider, one quotient bit per
// clock, MSB first. Only instantiated when ALU_DIV_EN is defined.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load                  capture dividend/divisor and start iterating
//   dividend, divisor     operands (divisor must be non-zero)
//   quotient, remainder   result of the step taken on the current clock;
//                         they are the final results while last is high
//   last                  high during the cycle whose edge performs the
//                         final (WIDTH-th) iteration
module alu_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;   // dividend bits shift out the top, quotient bits in the bottom
   logic [WIDTH-1:0] dvs_reg;
   logic [CW-1:0]    count_reg;
   logic             active_reg;

   logic [WIDTH:0]   trial;
   logic             fits;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The partial remainder
   // is always below the divisor, so the surviving value fits in WIDTH bits.
   always_comb begin
      trial     = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};
      fits      = ~trial[WIDTH];
      remainder = fits ? trial[WIDTH-1:0] : {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
      quotient  = {quo_reg[WIDTH-2:0], fits};
   end

   assign last = active_reg && (count_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
         count_reg  <= '0;
         active_reg <= 1'b0;
      end else if (load) begin
         rem_reg    <= '0;
         quo_reg    <= dividend;
         dvs_reg    <= divisor;
         count_reg  <= '0;
         active_reg <= 1'b1;
      end else if (active_reg) begin
         rem_reg   <= remainder;
         quo_reg   <= quotient;
         count_reg <= count_reg + CW'(1);
         if (last) begin
            active_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with start/busy/done handshake.
// Logic, add/sub and shift ops finish one clock after start; DIV/REM use
// the iterative alu_divider and take WIDTH+1 clocks (divide-by-zero is
// resolved in one clock).
// Build option: define ALU_DIV_EN to compile in the divider and DIV state;
// without it opcodes 1000/1001 behave as unknown opcodes and busy stays 0.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               issue request, accepted only while busy is low
//   cin                 carry/borrow in for ADD/SUB
//   alu_a, alu_b        operands (a: addend/subtrahend/divisor,
//                       b: dest/minuend/dividend)
//   alu_func            opcode
//   busy                divide in progress
//   done                one-cycle pulse, result and flags valid from here
//   alu_out             registered result, held until the next done
//   c, z, v, s          registered flags, updated only with done
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cin,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [3:0]       alu_func,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic             c,
   output logic             z,
   output logic             v,
   output logic             s
);

   alu_state_t           state_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [WIDTH-1:0]     out_reg;
   logic [NUM_FLAGS-1:0] flags_reg;

   logic [WIDTH:0]       sum_wide;
   logic [WIDTH:0]       diff_wide;
   logic [WIDTH-1:0]     op_res;
   logic                 op_c;
   logic                 op_v;
   logic [WIDTH-1:0]     wb_res;
   logic                 wb_c;
   logic                 wb_v;
   logic [NUM_FLAGS-1:0] wb_flags;

`ifdef ALU_DIV_EN
   logic                 rem_sel_reg;
   logic                 div_iter;
   logic                 div_load;
   logic [WIDTH-1:0]     div_quo;
   logic [WIDTH-1:0]     div_rem;
   logic                 div_last;

   // Only a non-zero divisor needs the iterative path.
   assign div_iter = ((alu_func == ALU_DIV) || (alu_func == ALU_REM)) && (alu_a != '0);
   assign div_load = (state_reg == IDLE) && start && div_iter;

   alu_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .dividend  (alu_b),
      .divisor   (alu_a),
      .quotient  (div_quo),
      .remainder (div_rem),
      .last      (div_last)
   );
`endif

   // Single-cycle datapath, evaluated on the live inputs so the result is
   // captured on the same edge that accepts the request.
   always_comb begin
      sum_wide  = {1'b0, alu_b} + {1'b0, alu_a} + {{WIDTH{1'b0}}, cin};
      diff_wide = {1'b0, alu_b} - {1'b0, alu_a} - {{WIDTH{1'b0}}, cin};
      op_res    = '0;
      op_c      = 1'b0;
      op_v      = 1'b0;
      case (alu_func)
         ALU_ADD: begin
            op_res = sum_wide[WIDTH-1:0];
            op_c   = sum_wide[WIDTH];
            op_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_wide[WIDTH-1] != alu_b[WIDTH-1]);
         end
         ALU_SUB: begin
            op_res = diff_wide[WIDTH-1:0];
            op_c   = diff_wide[WIDTH];   // wraps negative exactly when b < a+cin
            op_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_wide[WIDTH-1] != alu_b[WIDTH-1]);
         end
         ALU_AND: op_res = alu_a & alu_b;
         ALU_OR:  op_res = alu_a | alu_b;
         ALU_XOR: op_res = alu_a ^ alu_b;
         ALU_SHL: begin
            op_res = {alu_b[WIDTH-2:0], 1'b0};
            op_c   = alu_b[WIDTH-1];
         end
         ALU_SHR: begin
            op_res = {1'b0, alu_b[WIDTH-1:1]};
            op_c   = alu_b[0];
         end
         ALU_NOT: op_res = ~alu_b;
`ifdef ALU_DIV_EN
         // Used only for a divide by zero; otherwise the divider result wins.
         ALU_DIV: begin
            op_res = '1;
            op_v   = 1'b1;
         end
         ALU_REM: begin
            op_res = alu_b;
            op_v   = 1'b1;
         end
`endif
         default: op_res = '0;
      endcase
   end

   // Result/flag writeback source: divider while dividing, else the
   // single-cycle datapath.
   always_comb begin
      wb_res = op_res;
      wb_c   = op_c;
      wb_v   = op_v;
`ifdef ALU_DIV_EN
      if (state_reg == DIV) begin
         wb_res = rem_sel_reg ? div_rem : div_quo;
         wb_c   = 1'b0;
         wb_v   = 1'b0;
      end
`endif
      wb_flags         = '0;
      wb_flags[FLAG_C] = wb_c;
      wb_flags[FLAG_Z] = (wb_res == '0);
      wb_flags[FLAG_V] = wb_v;
      wb_flags[FLAG_S] = wb_res[WIDTH-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         out_reg     <= '0;
         flags_reg   <= '0;
`ifdef ALU_DIV_EN
         rem_sel_reg <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
`ifdef ALU_DIV_EN
                  if (div_iter) begin
                     state_reg   <= DIV;
                     busy_reg    <= 1'b1;
                     rem_sel_reg <= (alu_func == ALU_REM);
                  end else
`endif
                  begin
                     done_reg  <= 1'b1;
                     out_reg   <= wb_res;
                     flags_reg <= wb_flags;
                  end
               end
            end
`ifdef ALU_DIV_EN
            DIV: begin
               if (div_last) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  out_reg   <= wb_res;
                  flags_reg <= wb_flags;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign alu_out = out_reg;
   assign c       = flags_reg[FLAG_C];
   assign z       = flags_reg[FLAG_Z];
   assign v       = flags_reg[FLAG_V];
   assign s       = flags_reg[FLAG_S];

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=16). Works with or without ALU_DIV_EN.
// A reference model computes each accepted request with plain arithmetic
// and a remaining-cycles counter; a negedge process compares busy, done,
// alu_out and flags every cycle. Directed vectors add literal expectations.
module tb_alu_multicycle;

   localparam int W = 16;

`ifdef ALU_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif
   localparam int DLAT = DIV_ON ? W + 1 : 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         cin;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_func;
   logic         busy;
   logic         done;
   logic [W-1:0] alu_out;
   logic         c, z, v, s;

   int n_checks = 0;
   int n_pass   = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .cin      (cin),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_func (alu_func),
      .busy     (busy),
      .done     (done),
      .alu_out  (alu_out),
      .c        (c),
      .z        (z),
      .v        (v),
      .s        (s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference: result, flags {c,z,v,s} and cycles the request keeps the ALU busy.
   task automatic model_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, output logic [W-1:0] r, output logic [3:0] fl,
                           output int lat);
      int unsigned ai, bi, cii;
      logic cf, vf;
      ai = a; bi = b; cii = ci;
      cf = 1'b0; vf = 1'b0; lat = 0; r = '0;
      case (f)
         4'd0: begin
            r  = W'(bi + ai + cii);
            cf = (bi + ai + cii) > 32'h0000FFFF;
            vf = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]);
         end
         4'd1: begin
            r  = W'(bi - ai - cii);
            cf = bi < (ai + cii);
            vf = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin r = W'(bi * 2); cf = b[W-1]; end
         4'd6: begin r = W'(bi / 2); cf = b[0]; end
         4'd7: r = ~b;
         4'd8: if (DIV_ON) begin
            if (ai == 0) begin r = '1; vf = 1'b1; end
            else begin r = W'(bi / ai); lat = W; end
         end
         4'd9: if (DIV_ON) begin
            if (ai == 0) begin r = b; vf = 1'b1; end
            else begin r = W'(bi % ai); lat = W; end
         end
         default: r = '0;
      endcase
      fl = {cf, (r == '0), vf, r[W-1]};
   endtask

   // Model state: cycles left busy, done pulse, held outputs, pending result.
   int           m_cnt   = 0;
   logic         m_done  = 1'b0;
   logic [W-1:0] m_res   = '0;
   logic [3:0]   m_flags = '0;
   logic [W-1:0] p_res   = '0;
   logic [3:0]   p_flags = '0;

   always @(posedge clk or posedge reset) begin
      logic [W-1:0] r;
      logic [3:0]   fl;
      int           lat;
      if (reset) begin
         m_cnt   <= 0;
         m_done  <= 1'b0;
         m_res   <= '0;
         m_flags <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done  <= 1'b1;
               m_res   <= p_res;
               m_flags <= p_flags;
            end
         end else if (start) begin
            model_op(alu_func, alu_a, alu_b, cin, r, fl, lat);
            if (lat == 0) begin
               m_done  <= 1'b1;
               m_res   <= r;
               m_flags <= fl;
            end else begin
               m_cnt   <= lat;
               p_res   <= r;
               p_flags <= fl;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("done", 32'(done), 32'(m_done));
      check("alu_out", 32'(alu_out), 32'(m_res));
      check("flags", 32'({c, z, v, s}), 32'(m_flags));
   end

   // Issue one request and check it against literal expectations.
   // poke: cycle (after acceptance) in which a stray start is raised.
   // b2b: drive start in the current cycle (caller sits in a done cycle).
   task automatic run_op(input string name, input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci, input logic [W-1:0] exp_r,
                         input logic [3:0] exp_f, input int exp_lat, input int poke,
                         input bit b2b);
      int  i;
      bit  got;
      if (!b2b) begin
         @(posedge clk); #1;
      end
      alu_func = f; alu_a = a; alu_b = b; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble inputs: the DUT must use the captured copies.
      alu_a = W'($urandom); alu_b = W'($urandom); alu_func = 4'($urandom); cin = 1'($urandom);
      i = 1; got = 1'b0;
      while (i <= 40) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (i == poke) begin
            alu_func = 4'd0; alu_a = 16'h0101; alu_b = 16'h0202; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         i++;
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({name, "_latency"}, 32'(i), 32'(exp_lat));
         check({name, "_result"}, 32'(alu_out), 32'(exp_r));
         check({name, "_czvs"}, 32'({c, z, v, s}), 32'(exp_f));
      end
      $display("%-10s func=%b a=%h b=%h cin=%b -> out=%h czvs=%b cycles=%0d",
               name, f, a, b, ci, alu_out, {c, z, v, s}, i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; cin = 1'b0;
      alu_a = '0; alu_b = '0; alu_func = 4'd0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out", 32'(alu_out), 32'd0);
      check("rst_flags", 32'({c, z, v, s}), 32'd0);
      #2 reset = 1'b0;

      //      name        func   a         b         cin   result    czvs     lat poke b2b
      run_op("add_ovf",   4'd0,  16'h0001, 16'h7FFF, 1'b0, 16'h8000, 4'b0011, 1, 0, 0);
      run_op("add_carry", 4'd0,  16'h0001, 16'hFFFF, 1'b0, 16'h0000, 4'b1100, 1, 0, 0);
      run_op("sub_borrow",4'd1,  16'h0005, 16'h0003, 1'b0, 16'hFFFE, 4'b1001, 1, 0, 0);
      run_op("shl",       4'd5,  16'h5555, 16'h8001, 1'b0, 16'h0002, 4'b1000, 1, 0, 0);
      run_op("shr",       4'd6,  16'hAAAA, 16'h0001, 1'b0, 16'h0000, 4'b1100, 1, 0, 0);
      run_op("add_cin",   4'd0,  16'h0002, 16'h0003, 1'b1, 16'h0006, 4'b0000, 1, 0, 0);
      run_op("sub_cin",   4'd1,  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b1001, 1, 0, 0);
      run_op("sub_ovf",   4'd1,  16'h0001, 16'h8000, 1'b0, 16'h7FFF, 4'b0010, 1, 0, 0);
      run_op("and",       4'd2,  16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000, 1, 0, 0);
      run_op("or",        4'd3,  16'hF0F0, 16'h0FF0, 1'b0, 16'hFFF0, 4'b0001, 1, 0, 0);
      run_op("xor",       4'd4,  16'hF0F0, 16'h0FF0, 1'b0, 16'hFF00, 4'b0001, 1, 0, 0);
      run_op("not",       4'd7,  16'h1234, 16'hFFFF, 1'b0, 16'h0000, 4'b0100, 1, 0, 0);
      run_op("unknown",   4'd15, 16'h0001, 16'h0001, 1'b1, 16'h0000, 4'b0100, 1, 0, 0);
      run_op("div",       4'd8,  16'd7,    16'd100,  1'b0, DIV_ON ? 16'd14 : 16'd0,
             DIV_ON ? 4'b0000 : 4'b0100, DLAT, 5, 0);
      run_op("rem_b2b",   4'd9,  16'd7,    16'd100,  1'b0, DIV_ON ? 16'd2 : 16'd0,
             DIV_ON ? 4'b0000 : 4'b0100, DLAT, 5, 1);
      run_op("div_zero",  4'd8,  16'h0000, 16'h1234, 1'b0, DIV_ON ? 16'hFFFF : 16'h0000,
             DIV_ON ? 4'b0011 : 4'b0100, 1, 0, 0);
      run_op("rem_zero",  4'd9,  16'h0000, 16'h1234, 1'b0, DIV_ON ? 16'h1234 : 16'h0000,
             DIV_ON ? 4'b0010 : 4'b0100, 1, 0, 0);
      run_op("div_small", 4'd8,  16'd7,    16'd5,    1'b0, 16'h0000, 4'b0100, DLAT, 0, 0);
      run_op("rem_small", 4'd9,  16'd7,    16'd5,    1'b0, DIV_ON ? 16'd5 : 16'd0,
             DIV_ON ? 4'b0000 : 4'b0100, DLAT, 0, 1);
      run_op("div_max",   4'd8,  16'h0001, 16'hFFFF, 1'b0, DIV_ON ? 16'hFFFF : 16'h0000,
             DIV_ON ? 4'b0001 : 4'b0100, DLAT, 0, 0);

      // Asynchronous reset in the 5th cycle of a divide.
      @(posedge clk); #1;
      alu_func = 4'd8; alu_a = 16'd7; alu_b = 16'd100; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_out", 32'(alu_out), 32'd0);
      check("arst_flags", 32'({c, z, v, s}), 32'd0);
      $display("async reset during divide: busy=%b done=%b out=%h czvs=%b",
               busy, done, alu_out, {c, z, v, s});
      @(posedge clk);
      #3 reset = 1'b0;
      run_op("add_after", 4'd0,  16'h0010, 16'h0020, 1'b0, 16'h0030, 4'b0000, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
